apb_regfile: RTL

APB_REGFILE -- requirements
Module: apb_regfile

---
 rtl/apb_regfile.sv | 131 +++++++++++++
 1 files changed

// File: rtl/apb_regfile.sv
// rtl/apb_regfile.sv - APB register file with RW and RO banks, wait states, optional byte strobes (APB_REGFILE_PSTRB_EN)
module apb_regfile #(
   parameter int AWIDTH           = 4,
   parameter int DWIDTH           = 8,
   parameter int REGWN            = 5,
   parameter int REGRN            = 3,
   parameter int REGR_ADDR_OFFSET = 5,
   parameter int WAIT_CYCLES      = 0,
   parameter logic [DWIDTH-1:0] RST_VAL = '0
) (
   input  logic                      PCLK,
   input  logic                      PRESETn,
   input  logic                      PSEL,
   input  logic                      PENABLE,
   input  logic                      PWRITE,
   input  logic [AWIDTH-1:0]         PADDR,
   input  logic [DWIDTH-1:0]         PWDATA,
`ifdef APB_REGFILE_PSTRB_EN
   input  logic [DWIDTH/8-1:0]       PSTRB,
`endif
   output logic [DWIDTH-1:0]         PRDATA,
   output logic                      PREADY,
   output logic                      PSLVERR,
   output logic [REGWN*DWIDTH-1:0]   regw_out,
   output logic [REGWN-1:0]          regw_wstb,
   input  logic [REGRN*DWIDTH-1:0]   regr_in
);

   localparam int NLANES = DWIDTH / 8;
   localparam logic [3:0]  WAIT_N = 4'(WAIT_CYCLES);
   localparam logic [31:0] RW_END = 32'(REGWN);
   localparam logic [31:0] RO_LO  = 32'(REGR_ADDR_OFFSET);
   localparam logic [31:0] RO_HI  = 32'(REGR_ADDR_OFFSET + REGRN);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   // state holds the bus phase seen in the previous cycle
   state_t state, next_state;

   logic [3:0]              wait_cnt;
   logic                    in_access;
   logic                    ready;
   logic [31:0]             addr_ext;
   logic                    rw_hit;
   logic                    ro_hit;
   logic                    err;
   logic                    wr_commit;
   logic [NLANES-1:0]       lane_en;
   logic [DWIDTH-1:0]       rd_word;
   logic [REGWN*DWIDTH-1:0] regw_q;

`ifdef APB_REGFILE_PSTRB_EN
   assign lane_en = PSTRB;
`else
   assign lane_en = '1;
`endif

   // An access cycle is only honoured when it follows a setup or an ongoing access
   assign in_access = PSEL && PENABLE && (state != IDLE);
   assign ready     = in_access && (wait_cnt == WAIT_N);

   // Full decode: any non-zero upper PADDR bit lands outside both banks
   assign addr_ext  = 32'(PADDR);
   assign rw_hit    = addr_ext < RW_END;
   assign ro_hit    = (addr_ext >= RO_LO) && (addr_ext < RO_HI);
   assign err       = !(rw_hit || ro_hit) || (PWRITE && ro_hit);
   assign wr_commit = ready && PWRITE && rw_hit && (|lane_en);

   // State register; reset abandons any transfer in flight
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) state <= IDLE;
      else          state <= next_state;
   end

   // Next phase: a new setup wins, a stalled access holds, anything else drops to idle
   always_comb begin
      next_state = IDLE;
      if (PSEL && !PENABLE)
         next_state = SETUP;
      else if (in_access && !ready)
         next_state = ACCESS;
   end

   // Wait-state counter: counts access cycles, saturating at the ready point
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn)
         wait_cnt <= '0;
      else if (!in_access || ready)
         wait_cnt <= '0;
      else if (wait_cnt != WAIT_N)
         wait_cnt <= wait_cnt + 4'd1;
   end

   // Register bank update and one-cycle write strobes
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         regw_q    <= {REGWN{RST_VAL}};
         regw_wstb <= '0;
      end else begin
         regw_wstb <= '0;
         for (int i = 0; i < REGWN; i++) begin
            if (wr_commit && (addr_ext == 32'(i))) begin
               regw_wstb[i] <= 1'b1;
               for (int b = 0; b < NLANES; b++) begin
                  if (lane_en[b])
                     regw_q[i*DWIDTH + b*8 +: 8] <= PWDATA[b*8 +: 8];
               end
            end
         end
      end
   end

   // Read mux across both banks
   always_comb begin
      rd_word = '0;
      for (int i = 0; i < REGWN; i++) begin
         if (addr_ext == 32'(i))
            rd_word = regw_q[i*DWIDTH +: DWIDTH];
      end
      for (int i = 0; i < REGRN; i++) begin
         if (addr_ext == RO_LO + 32'(i))
            rd_word = regr_in[i*DWIDTH +: DWIDTH];
      end
   end

   assign regw_out = regw_q;
   assign PREADY   = ready;
   assign PSLVERR  = ready && err;
   assign PRDATA   = (ready && !PWRITE && !err) ? rd_word : '0;

endmodule
